// File: rtl/auto_delay_trainer_if.sv
// rtl/auto_delay_trainer_if.sv - start/lane-data/tap-control bundle between the IDELAY trainer and its environment
interface auto_delay_trainer_if #(
  parameter int LANES = 8,
  parameter int TAP_W = 5
);
  logic                   start;
  logic [LANES-1:0]       data_in;
  logic [LANES*TAP_W-1:0] tap_value;
  logic [LANES-1:0]       tap_load;
  logic                   busy;
  logic                   done;
  logic [LANES-1:0]       lane_fail;
`ifdef AUTO_DELAY_EYE_REPORT_EN
  logic [LANES*(TAP_W+1)-1:0] eye_width;

  modport master (input start, data_in,
                  output tap_value, tap_load, busy, done, lane_fail, eye_width);
  modport slave  (output start, data_in,
                  input tap_value, tap_load, busy, done, lane_fail, eye_width);
`else
  modport master (input start, data_in,
                  output tap_value, tap_load, busy, done, lane_fail);
  modport slave  (output start, data_in,
                  input tap_value, tap_load, busy, done, lane_fail);
`endif
endinterface

// File: rtl/auto_delay_trainer.sv
// rtl/auto_delay_trainer.sv - per-lane IDELAYE2 tap sweep, widest-eye centring; AUTO_DELAY_EYE_REPORT_EN adds eye_width
module auto_delay_trainer #(
  parameter int LANES       = 8,
  parameter int TAP_W       = 5,
  parameter int TAP_DEFAULT = 16,
  parameter int SETTLE      = 4,
  parameter int DWELL       = 16,
  parameter int MIN_EYE     = 3
) (
  input logic                  sample_clk,
  input logic                  reset_n,
  auto_delay_trainer_if.master bus
);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;
  localparam logic [TAP_W-1:0] TAP_DEF = TAP_W'(TAP_DEFAULT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_EVAL, S_APPLY, S_NEXT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LANES-1:0] d_q, d_prev;
  logic [LW-1:0]    lane;
  logic [TAP_W-1:0] tap;
  logic [CW-1:0]    cnt;
  logic             err;
  logic [TAP_W:0]   cur_len, best_len;
  logic [TAP_W-1:0] cur_start, best_start;
  logic [TAP_W-1:0] tap_reg [LANES];
  logic [LANES-1:0] fail_q;

  logic             lane_pass;
  logic             eye_ok;
  logic [TAP_W:0]   half_len;
  logic [TAP_W-1:0] apply_tap;
  logic [TAP_W:0]   cur_len_inc;
  logic [TAP_W-1:0] cur_start_new;

  // A training lane passes a cycle when its data toggled since the previous sample.
  assign lane_pass     = d_q[lane] != d_prev[lane];
  assign eye_ok        = best_len >= (TAP_W+1)'(MIN_EYE);
  assign half_len      = (best_len - 1'b1) >> 1;
  assign apply_tap     = eye_ok ? (best_start + half_len[TAP_W-1:0]) : TAP_DEF;
  assign cur_len_inc   = cur_len + 1'b1;
  assign cur_start_new = (cur_len == '0) ? tap : cur_start;
  assign bus.lane_fail = fail_q;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.tap_load = '0;
    bus.busy     = (state != S_IDLE) && (state != S_DONE);
    bus.done     = (state == S_DONE);
    for (int i = 0; i < LANES; i++) bus.tap_value[i*TAP_W +: TAP_W] = tap_reg[i];
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt                            = S_SETTLE;
        bus.tap_load[lane]                   = 1'b1;
        bus.tap_value[lane*TAP_W +: TAP_W]   = tap;
      end
      S_SETTLE:  if (cnt == CW'(SETTLE - 1)) state_nxt = S_MEASURE;
      S_MEASURE: if (cnt == CW'(DWELL - 1))  state_nxt = S_EVAL;
      S_EVAL:    state_nxt = (tap == TAP_MAX) ? S_APPLY : S_LOAD;
      S_APPLY: begin
        state_nxt                            = S_NEXT;
        bus.tap_load[lane]                   = 1'b1;
        bus.tap_value[lane*TAP_W +: TAP_W]   = apply_tap;
      end
      S_NEXT:    state_nxt = (lane == LW'(LANES - 1)) ? S_DONE : S_LOAD;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

`ifdef AUTO_DELAY_EYE_REPORT_EN
  logic [LANES*(TAP_W+1)-1:0] eye_q;
  assign bus.eye_width = eye_q;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n)                             eye_q <= '0;
    else if (state == S_IDLE && bus.start)    eye_q <= '0;
    else if (state == S_APPLY)                eye_q[lane*(TAP_W+1) +: TAP_W+1] <= best_len;
  end
`endif

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q        <= '0;
      d_prev     <= '0;
      lane       <= '0;
      tap        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      cur_len    <= '0;
      best_len   <= '0;
      cur_start  <= '0;
      best_start <= '0;
      fail_q     <= '0;
      for (int i = 0; i < LANES; i++) tap_reg[i] <= TAP_DEF;
    end else begin
      d_q    <= bus.data_in;
      d_prev <= d_q;
      case (state)
        S_IDLE: if (bus.start) begin
          lane       <= '0;
          tap        <= '0;
          fail_q     <= '0;
          cur_len    <= '0;
          best_len   <= '0;
          cur_start  <= '0;
          best_start <= '0;
        end
        S_LOAD: begin
          tap_reg[lane] <= tap;
          cnt           <= '0;
          err           <= 1'b0;
        end
        S_SETTLE:  cnt <= (cnt == CW'(SETTLE - 1)) ? '0 : cnt + 1'b1;
        S_MEASURE: begin
          cnt <= cnt + 1'b1;
          if (!lane_pass) err <= 1'b1;
        end
        S_EVAL: begin
          if (!err) begin
            cur_len   <= cur_len_inc;
            cur_start <= cur_start_new;
            // Strictly longer only, so ties keep the lowest-tap window.
            if (cur_len_inc > best_len) begin
              best_len   <= cur_len_inc;
              best_start <= cur_start_new;
            end
          end else begin
            cur_len <= '0;
          end
          if (tap != TAP_MAX) tap <= tap + 1'b1;
        end
        S_APPLY: begin
          tap_reg[lane] <= apply_tap;
          if (!eye_ok) fail_q[lane] <= 1'b1;
        end
        S_NEXT: begin
          cur_len    <= '0;
          best_len   <= '0;
          cur_start  <= '0;
          best_start <= '0;
          err        <= 1'b0;
          if (lane != LW'(LANES - 1)) begin
            lane <= lane + 1'b1;
            tap  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_auto_delay_trainer.sv
// tb/tb_auto_delay_trainer.sv - two-lane bench: emulated IDELAY eye masks against a window-search model
module tb_auto_delay_trainer;
  localparam int LANE_CYC = 32 * 22 + 2;
  localparam int DONE_T   = 2 * LANE_CYC + 1;

  logic sample_clk = 1'b0;
  logic reset_n;

  auto_delay_trainer_if #(.LANES(2), .TAP_W(5)) bus ();

  auto_delay_trainer #(
    .LANES(2), .TAP_W(5), .TAP_DEFAULT(16), .SETTLE(4), .DWELL(16), .MIN_EYE(3)
  ) dut (
    .sample_clk(sample_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 sample_clk = ~sample_clk;

  int          checks, errors;
  logic [31:0] pass_mask [2];
  int          loaded_tap [2];
  int          res_tap [2];
  int          res_len [2];
  bit          res_fail [2];
  int          prev_hold [2];
  int          lane_pulses [2];
  int          t;
  bit          tracking;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic logic [31:0] win(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Enumerate maximal runs of passing taps; keep the first longest one.
  function automatic void eye_model(input logic [31:0] m, output int ctr, output bit fail, output int blen);
    int best_s, len;
    best_s = 0;
    blen   = 0;
    for (int s = 0; s < 32; s++) begin
      if (m[s] && (s == 0 || !m[s-1])) begin
        len = 0;
        while (s + len < 32 && m[s+len]) len++;
        if (len > blen) begin
          blen   = len;
          best_s = s;
        end
      end
    end
    fail = blen < 3;
    ctr  = fail ? 16 : best_s + (blen - 1) / 2;
  endfunction

  // Emulated delay line: a lane toggles only while its loaded tap lies inside its eye mask.
  always @(negedge sample_clk) begin
    for (int l = 0; l < 2; l++) begin
      if (bus.tap_load[l]) loaded_tap[l] = int'(bus.tap_value[l*5 +: 5]);
      if (pass_mask[l][loaded_tap[l]]) bus.data_in[l] = ~bus.data_in[l];
    end
  end

  always @(negedge sample_clk) begin
    int         ln, o;
    logic [1:0] eload, efail;
    logic [9:0] etap;
    logic       ebusy, edone;
    if (tracking) begin
      t++;
      eload = '0;
      efail = '0;
      etap  = '0;
      if (t < DONE_T) begin
        ln    = (t - 1) / LANE_CYC;
        o     = (t - 1) % LANE_CYC;
        ebusy = 1'b1;
        edone = 1'b0;
        if ((o < 704 && o % 22 == 0) || o == 704) eload[ln] = 1'b1;
        for (int l = 0; l < 2; l++) begin
          if (l < ln) begin
            etap[l*5 +: 5] = 5'(res_tap[l]);
            efail[l]       = res_fail[l];
          end else if (l > ln) begin
            etap[l*5 +: 5] = 5'(prev_hold[l]);
          end else begin
            etap[l*5 +: 5] = (o < 704) ? 5'(o / 22) : 5'(res_tap[l]);
            efail[l]       = (o == 705) && res_fail[l];
          end
        end
      end else begin
        ebusy = 1'b0;
        edone = 1'b1;
        for (int l = 0; l < 2; l++) begin
          etap[l*5 +: 5] = 5'(res_tap[l]);
          efail[l]       = res_fail[l];
        end
      end
      chk("tap_load", bus.tap_load, eload);
      chk("busy_done", {bus.busy, bus.done}, {ebusy, edone});
      chk("tap_value", bus.tap_value, etap);
      chk("lane_fail", bus.lane_fail, efail);
      for (int l = 0; l < 2; l++) if (bus.tap_load[l]) lane_pulses[l]++;
      if (t == DONE_T) begin
        chk("pulses_lane0", lane_pulses[0], 33);
        chk("pulses_lane1", lane_pulses[1], 33);
        tracking = 1'b0;
      end
    end
  end

  task automatic launch(input logic [31:0] m0, input logic [31:0] m1);
    pass_mask[0] = m0;
    pass_mask[1] = m1;
    for (int l = 0; l < 2; l++) eye_model(pass_mask[l], res_tap[l], res_fail[l], res_len[l]);
    @(posedge sample_clk);
    #2 bus.start = 1'b1;
    @(posedge sample_clk);
    #2 bus.start = 1'b0;
    t              = 0;
    lane_pulses[0] = 0;
    lane_pulses[1] = 0;
    tracking       = 1'b1;
  endtask

  task automatic run_train(input string nm, input logic [31:0] m0, input logic [31:0] m1,
                           input int mid_start, input int exp0, input int exp1,
                           input logic [1:0] expf);
    launch(m0, m1);
    chk({nm, "_model0"}, res_tap[0], exp0);
    chk({nm, "_model1"}, res_tap[1], exp1);
    chk({nm, "_modelf"}, {res_fail[1], res_fail[0]}, expf);
    if (mid_start > 0) begin
      repeat (mid_start) @(posedge sample_clk);
      #2 bus.start = 1'b1;
      @(posedge sample_clk);
      #2 bus.start = 1'b0;
    end
    for (int i = 0; i < 3000 && tracking; i++) @(posedge sample_clk);
    if (tracking) begin
      chk({nm, "_timeout"}, 1, 0);
      tracking = 1'b0;
    end
    #2;
    chk({nm, "_tap0"}, bus.tap_value[4:0], exp0);
    chk({nm, "_tap1"}, bus.tap_value[9:5], exp1);
    chk({nm, "_fail"}, bus.lane_fail, expf);
`ifdef AUTO_DELAY_EYE_REPORT_EN
    chk({nm, "_eye0"}, bus.eye_width[5:0], res_len[0]);
    chk({nm, "_eye1"}, bus.eye_width[11:6], res_len[1]);
`endif
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_no_extra_done"}, bus.done, 1'b0);
      @(posedge sample_clk);
      #1;
    end
    prev_hold[0] = exp0;
    prev_hold[1] = exp1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    t             = 0;
    tracking      = 1'b0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.data_in   = '0;
    pass_mask[0]  = '0;
    pass_mask[1]  = '0;
    loaded_tap[0] = 16;
    loaded_tap[1] = 16;
    prev_hold[0]  = 16;
    prev_hold[1]  = 16;
    repeat (3) @(posedge sample_clk);
    #1;
    chk("rst_tap_value", bus.tap_value, 10'h210);
    chk("rst_tap_load", bus.tap_load, 2'b00);
    chk("rst_busy_done", {bus.busy, bus.done}, 2'b00);
    chk("rst_lane_fail", bus.lane_fail, 2'b00);
    #1 reset_n = 1'b1;

    run_train("centre", win(8, 20), '1, 0, 14, 15, 2'b00);
    run_train("widest", win(2, 5) | win(20, 27), '1, 900, 23, 15, 2'b00);
    run_train("tie", win(3, 6) | win(10, 13), win(0, 31), 0, 4, 15, 2'b00);
`ifdef AUTO_DELAY_EYE_REPORT_EN
    chk("tie_eye_literal", bus.eye_width[5:0], 6'd4);
`endif
    run_train("static", '0, '1, 0, 16, 15, 2'b01);
    run_train("narrow", win(9, 10), win(5, 9), 0, 16, 7, 2'b01);
    run_train("edges", win(0, 2), win(29, 31), 0, 1, 30, 2'b00);

    launch(win(8, 20), '1);
    repeat (800) @(posedge sample_clk);
    #2;
    tracking = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_tap_value", bus.tap_value, 10'h210);
    chk("midrst_tap_load", bus.tap_load, 2'b00);
    chk("midrst_lane_fail", bus.lane_fail, 2'b00);
`ifdef AUTO_DELAY_EYE_REPORT_EN
    chk("midrst_eye", bus.eye_width, 12'h000);
`endif
    @(posedge sample_clk);
    #2 reset_n = 1'b1;
    prev_hold[0] = 16;
    prev_hold[1] = 16;
    run_train("after_rst", win(8, 20), '1, 0, 14, 15, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
